// File: rtl/coco3_mem_arbiter_if.sv
// coco3_mem_arbiter_if: request, download, CPU and memory bus bundle.
// Ports: none; slave = arbiter side, master = requesters + memory side.
interface coco3_mem_arbiter_if #(
    parameter int AW = 21
);
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [7:0]    vid_rdata;
    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_data;
    logic          dl_wait;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_ack;
    logic [7:0]    cpu_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          mem_ack;
    logic          err_timeout;
    logic          err_dl_ovf;

    modport slave (
        input  vid_req, vid_addr,
        input  dl_wr, dl_addr, dl_data,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  mem_rdata, mem_ack,
        output vid_ack, vid_rdata, dl_wait,
        output cpu_ack, cpu_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output err_timeout, err_dl_ovf
    );

    modport master (
        output vid_req, vid_addr,
        output dl_wr, dl_addr, dl_data,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output mem_rdata, mem_ack,
        input  vid_ack, vid_rdata, dl_wait,
        input  cpu_ack, cpu_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  err_timeout, err_dl_ovf
    );
endinterface

// File: rtl/coco3_mem_arbiter.sv
// coco3_mem_arbiter: shares one memory port between video, download, CPU.
// Ports: clk_sys, reset_n (async, active-low), bus (slave modport).
module coco3_mem_arbiter #(
    parameter int AW         = 21,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    coco3_mem_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [1:0] OWN_VID = 2'd0;
    localparam logic [1:0] OWN_DL  = 2'd1;
    localparam logic [1:0] OWN_CPU = 2'd2;

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    r_state;
    logic [1:0]    r_own;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_wdata;
    logic          r_dl_full;
    logic [AW-1:0] r_dl_addr;
    logic [7:0]    r_dl_data;
    logic [SW-1:0] r_starve;
    logic [TW-1:0] r_timer;
    logic          r_vid_ack;
    logic          r_cpu_ack;
    logic [7:0]    r_vid_rdata;
    logic [7:0]    r_cpu_rdata;
    logic          r_err_to;
    logic          r_err_ovf;

    logic          w_grant;
    logic [1:0]    w_own;
    logic          w_expire;
    logic          w_end;
    logic          w_busy;

    assign w_grant  = (r_state == S_IDLE) &
                      (bus.vid_req | r_dl_full | bus.cpu_req);
    // Last permitted WAIT cycle: timer started at 0 on entry.
    assign w_expire = (r_timer == TW'(TIMEOUT - 1));
    assign w_end    = (r_state == S_WAIT) & (bus.mem_ack | w_expire);
    assign w_busy   = (r_state == S_ISSUE) | (r_state == S_WAIT);

    // Starved CPU beats everything; otherwise vid > dl > cpu.
    always_comb begin
        w_own = OWN_CPU;
        if (bus.cpu_req && r_starve == SW'(STARVE_MAX))
            w_own = OWN_CPU;
        else if (bus.vid_req)
            w_own = OWN_VID;
        else if (r_dl_full)
            w_own = OWN_DL;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_own   <= OWN_VID;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_timer <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_grant) begin
                    r_state <= S_ISSUE;
                    r_own   <= w_own;
                    r_timer <= '0;
                    case (w_own)
                        OWN_VID: begin
                            r_we    <= 1'b0;
                            r_addr  <= bus.vid_addr;
                            r_wdata <= '0;
                        end
                        OWN_DL: begin
                            r_we    <= 1'b1;
                            r_addr  <= r_dl_addr;
                            r_wdata <= r_dl_data;
                        end
                        default: begin
                            r_we    <= bus.cpu_we;
                            r_addr  <= bus.cpu_addr;
                            r_wdata <= bus.cpu_wdata;
                        end
                    endcase
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (w_end)
                        r_state <= S_IDLE;
                    else
                        r_timer <= r_timer + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Completion: ack next cycle; mem_ack absent at w_end means abort.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_vid_ack   <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_vid_rdata <= '0;
            r_cpu_rdata <= '0;
            r_err_to    <= 1'b0;
        end else begin
            r_vid_ack <= w_end & (r_own == OWN_VID);
            r_cpu_ack <= w_end & (r_own == OWN_CPU);
            if (w_end) begin
                if (!bus.mem_ack) begin
                    r_err_to <= 1'b1;
                    if (r_own == OWN_VID) r_vid_rdata <= 8'hFF;
                    if (r_own == OWN_CPU) r_cpu_rdata <= 8'hFF;
                end else if (!r_we) begin
                    if (r_own == OWN_VID) r_vid_rdata <= bus.mem_rdata;
                    if (r_own == OWN_CPU) r_cpu_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_dl_full <= 1'b0;
            r_dl_addr <= '0;
            r_dl_data <= '0;
            r_err_ovf <= 1'b0;
        end else begin
            if (w_end && r_own == OWN_DL) begin
                r_dl_full <= 1'b0;
            end else if (bus.dl_wr && !r_dl_full) begin
                r_dl_full <= 1'b1;
                r_dl_addr <= bus.dl_addr;
                r_dl_data <= bus.dl_data;
            end
            if (bus.dl_wr && r_dl_full)
                r_err_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= '0;
        end else if (!bus.cpu_req) begin
            r_starve <= '0;
        end else if (w_grant) begin
            if (w_own == OWN_CPU)
                r_starve <= '0;
            else if (r_starve != SW'(STARVE_MAX))
                r_starve <= r_starve + 1'b1;
        end
    end

    assign bus.mem_req     = w_busy;
    assign bus.mem_we      = r_we & w_busy;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_wdata   = r_wdata;
    assign bus.vid_ack     = r_vid_ack;
    assign bus.vid_rdata   = r_vid_rdata;
    assign bus.cpu_ack     = r_cpu_ack;
    assign bus.cpu_rdata   = r_cpu_rdata;
    assign bus.dl_wait     = r_dl_full;
    assign bus.err_timeout = r_err_to;
    assign bus.err_dl_ovf  = r_err_ovf;

endmodule

// File: doc/coco3_mem_arbiter.md
COCO3_MEM_ARBITER -- requirements
Module: coco3_mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning): AW, 21, memory address width; STARVE_MAX, 4, max consecutive non-CPU grants while cpu_req is pending; TIMEOUT, 255, cycles allowed for mem_ack before abort.
REQ-002 Ports (name direction width meaning), one per line:
clk_sys  in  1  sole clock; all logic rising-edge.
reset_n  in  1  asynchronous, active-low reset.
vid_req  in  1  video fetch request; level, held until vid_ack.
vid_addr  in  AW  video read address.
vid_ack  out  1  one-cycle pulse; vid_rdata valid this cycle.
vid_rdata  out  8  video read data.
dl_wr  in  1  download write strobe; one-cycle pulse.
dl_addr  in  AW  download address.
dl_data  in  8  download data.
dl_wait  out  1  download back-pressure; high while the buffer is full.
cpu_req  in  1  CPU request; level, held until cpu_ack.
cpu_we  in  1  CPU write when 1, read when 0.
cpu_addr  in  AW  CPU address.
cpu_wdata  in  8  CPU write data.
cpu_ack  out  1  one-cycle pulse; cpu_rdata valid on reads.
cpu_rdata  out  8  CPU read data.
mem_req  out  1  memory request; held until mem_ack or abort.
mem_we  out  1  memory write enable.
mem_addr  out  AW  memory address.
mem_wdata  out  8  memory write data.
mem_rdata  in  8  memory read data; valid with mem_ack.
mem_ack  in  1  memory completion pulse.
err_timeout  out  1  sticky; a transaction was aborted.
err_dl_ovf  out  1  sticky; a dl_wr arrived while the buffer was full.

Function
REQ-003 Download buffer: one entry of address and data; dl_wr while empty captures dl_addr and dl_data and sets full in the next cycle.
REQ-004 dl_wait equals buffer-full, registered; dl_wr while full is dropped, the buffer is unchanged, and err_dl_ovf is set.
REQ-005 FSM states: IDLE, ISSUE, WAIT.
REQ-006 IDLE: when any request is pending, the arbiter latches the winner, its address, data and we, then goes to ISSUE; with no request pending it stays in IDLE.
REQ-007 Priority order: vid > dl buffer > cpu.
REQ-008 Starvation override: when cpu_req is pending and starve_cnt equals STARVE_MAX, the CPU wins regardless of other requests.
REQ-009 starve_cnt: increments on each non-CPU grant while cpu_req is high; clears on a CPU grant or when cpu_req is low; saturates at STARVE_MAX.
REQ-010 ISSUE: mem_req, mem_we, mem_addr and mem_wdata are driven from the latched values for one cycle, then the FSM goes to WAIT; mem_req stays high through WAIT.
REQ-011 WAIT: on mem_ack, mem_req drops in the same cycle, the owner's ack pulses in the next cycle with rdata registered from mem_rdata, and the FSM returns to IDLE; a dl grant empties the buffer in that same cycle.
REQ-012 Minimum latency from request to ack is 4 cycles (IDLE, ISSUE, WAIT with mem_ack, ack); back-to-back grants are separated by one IDLE cycle.
REQ-013 Video grants are always reads (mem_we=0); dl grants are always writes; for dl and CPU writes the ack carries no data and rdata holds its previous value.
REQ-014 Timeout: a timer counts in WAIT; when it reaches TIMEOUT without mem_ack, the arbiter drops mem_req, pulses the owner's ack with rdata=8'hFF, sets err_timeout, and returns to IDLE.
REQ-015 A mem_ack arriving outside WAIT is ignored.
REQ-016 A requester dropping req mid-transaction does not abort it; its ack still pulses.
REQ-017 A request and its ack in the same cycle for different requesters is legal; the arbiter is evaluated in IDLE only.
REQ-018 err_* flags clear only on reset.

Reset
REQ-019 reset_n low asynchronously forces: FSM=IDLE; all acks, mem_req, mem_we, dl_wait, err_* = 0; mem_addr, mem_wdata, rdata outputs = 0; buffer empty; starve_cnt and timer = 0.
REQ-020 Reset mid-transaction abandons it with no ack; first arbitration happens in the first cycle after reset_n rises.

Verification
REQ-021 Single CPU read at addr 0x01234, memory acks after 2 cycles with 0x5A -> cpu_ack 1 cycle after mem_ack, cpu_rdata=0x5A, total 5 cycles.
REQ-022 vid_req held continuously with cpu_req pending -> CPU granted after exactly 4 video grants; starve_cnt then 0.
REQ-023 dl_wr at 0x00010/0xA5, then a second dl_wr while dl_wait=1 -> memory write 0x00010=0xA5 only; err_dl_ovf=1; dl_wait falls on the completion cycle.
REQ-024 Memory never acks a video read -> abort after 255 WAIT cycles; vid_ack with 0xFF; err_timeout=1; next request serviced normally.
REQ-025 vid, dl and cpu all requesting in the same IDLE cycle with starve_cnt=0 -> grant order vid, dl, cpu (vid_req dropped after its ack).
REQ-026 reset_n low during WAIT -> mem_req low immediately, no ack; after release, the pending cpu_req is served normally.
